// File: rtl/text_pkg.sv
// Shared constants, character codes and FSM state type for the text overlay writer.
package text_pkg;

  localparam int unsigned TXT_COLS = 40;
  localparam int unsigned TXT_ROWS = 15;
  localparam int unsigned ROW_W    = 4;
  localparam int unsigned COL_W    = 6;
  localparam int unsigned CHAR_W   = 7;

  localparam logic [CHAR_W-1:0] CHR_NUL      = 7'h00;
  localparam logic [CHAR_W-1:0] CHR_BS       = 7'h08;
  localparam logic [CHAR_W-1:0] CHR_LF       = 7'h0A;
  localparam logic [CHAR_W-1:0] CHR_FF       = 7'h0C;
  localparam logic [CHAR_W-1:0] CHR_PRINT_LO = 7'h20;
  localparam logic [CHAR_W-1:0] CHR_PRINT_HI = 7'h7E;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } wr_state_e;

  function automatic logic is_printable(input logic [CHAR_W-1:0] c);
    return (c >= CHR_PRINT_LO) && (c <= CHR_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor row/column registers with load, advance, newline, back and home operations.
module text_cursor
  import text_pkg::*;
#(
  parameter int unsigned COLS = TXT_COLS,
  parameter int unsigned ROWS = TXT_ROWS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [ROW_W-1:0] load_row_i,
  input  logic [COL_W-1:0] load_col_i,
  input  logic             adv_i,
  input  logic             nl_i,
  input  logic             back_i,
  input  logic             home_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_nxt_c_o,
  output logic [COL_W-1:0] col_nxt_c_o
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  logic [ROW_W-1:0] row_q, row_d, row_inc, row_dec;
  logic [COL_W-1:0] col_q, col_d;

  assign row_inc = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
  assign row_dec = (row_q == '0) ? ROW_MAX : row_q - ROW_W'(1);

  // Operations are mutually exclusive in practice; home wins, then load.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (home_i) begin
      row_d = '0;
      col_d = '0;
    end else if (load_i) begin
      row_d = (load_row_i > ROW_MAX) ? ROW_MAX : load_row_i;
      col_d = (load_col_i > COL_MAX) ? COL_MAX : load_col_i;
    end else if (back_i) begin
      if (col_q == '0) begin
        col_d = COL_MAX;
        row_d = row_dec;
      end else begin
        col_d = col_q - COL_W'(1);
      end
    end else if (nl_i) begin
      col_d = '0;
      row_d = row_inc;
    end else if (adv_i) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = row_inc;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o       = row_q;
  assign col_o       = col_q;
  assign row_nxt_c_o = row_d;
  assign col_nxt_c_o = col_d;

endmodule

// File: rtl/text_buffer_writer.sv
// Character-tile RAM writer: streams ASCII into the text grid, with a clear pass after reset/FF.
// Optional TEXT_WRITER_BACKSPACE_EN: 0x08 steps the cursor back and blanks that cell.
module text_buffer_writer
  import text_pkg::*;
#(
  parameter int unsigned COLS   = TXT_COLS,
  parameter int unsigned ROWS   = TXT_ROWS,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              char_valid,
  input  logic [CHAR_W-1:0] char_data,
  output logic              char_ready,
  input  logic              cur_set,
  input  logic [ROW_W-1:0]  cur_row,
  input  logic [COL_W-1:0]  cur_col,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CHAR_W-1:0] wr_data,
  output logic              busy,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [COL_W-1:0]  cursor_col
);

  localparam int unsigned       CELLS     = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CHAR_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;

  logic              accept_c;
  logic              cur_load, cur_adv, cur_nl, cur_back, cur_home;
  logic [ROW_W-1:0]  row_nxt, tgt_row;
  logic [COL_W-1:0]  col_nxt, tgt_col;

  // Row base is row*40 built from shifts; the grid is 40 cells wide.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return ADDR_W'({r, 5'b0}) + ADDR_W'({r, 3'b0}) + ADDR_W'(c);
  endfunction

  text_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (cur_load),
    .load_row_i  (cur_row),
    .load_col_i  (cur_col),
    .adv_i       (cur_adv),
    .nl_i        (cur_nl),
    .back_i      (cur_back),
    .home_i      (cur_home),
    .row_o       (cursor_row),
    .col_o       (cursor_col),
    .row_nxt_c_o (row_nxt),
    .col_nxt_c_o (col_nxt)
  );

  assign char_ready = (state_q == ST_IDLE) && !busy_q && !cur_set;
  assign accept_c   = char_valid && char_ready;

  // Backspace blanks the cell it moves to; every other write lands at the current cursor.
  assign tgt_row = cur_back ? row_nxt : cursor_row;
  assign tgt_col = cur_back ? col_nxt : cursor_col;

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cur_load  = 1'b0;
    cur_adv   = 1'b0;
    cur_nl    = 1'b0;
    cur_back  = 1'b0;
    cur_home  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_q;
        wr_data_d = CHR_NUL;
        if (clr_q == LAST_ADDR) begin
          state_d  = ST_IDLE;
          clr_d    = '0;
          cur_home = 1'b1;
        end else begin
          clr_d = clr_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (cur_set) begin
          cur_load = 1'b1;
        end else if (accept_c) begin
          if (is_printable(char_data)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr(tgt_row, tgt_col);
            wr_data_d = char_data;
            cur_adv   = 1'b1;
          end else if (char_data == CHR_LF) begin
            cur_nl = 1'b1;
          end else if (char_data == CHR_FF) begin
            // First clear write issues straight from the FF handshake.
            state_d   = ST_CLEAR;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = CHR_NUL;
            clr_d     = ADDR_W'(1);
            cur_home  = 1'b1;
          end
`ifdef TEXT_WRITER_BACKSPACE_EN
          else if (char_data == CHR_BS) begin
            cur_back  = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr(tgt_row, tgt_col);
            wr_data_d = CHR_NUL;
          end
`endif
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // busy covers the final clear write and drops the cycle after it.
  assign busy_d = (state_q == ST_CLEAR) || (state_d == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule
